// File: rtl/round_sat_arbiter_if.sv
// Requester/result handshake bundle for round_sat_arbiter.
// master = requesters plus result sink, slave = the arbiter itself.
interface round_sat_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 mode;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [ID_W-1:0]      out_id;
  logic                 sat_flag;
  logic                 out_ready;

  modport master (
    output req_valid, req_data, mode, out_ready,
    input  req_ready, out_valid, out_data, out_id, sat_flag
  );

  modport slave (
    input  req_valid, req_data, mode, out_ready,
    output req_ready, out_valid, out_data, out_id, sat_flag
  );
endinterface

// File: rtl/round_sat_arbiter.sv
// Round-robin shared round-and-saturate unit: one registered result per cycle.
// SAT_STATS_EN adds a saturating count of clamped results (o_sat_count, i_stats_clr).
module round_sat_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          IN_W      = 16,
  parameter int          FRAC_W    = 6,
  parameter int          OUT_W     = 10,
  parameter int          SAT_MAX   = 255,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef SAT_STATS_EN
  input  logic                i_stats_clr,
  output logic [15:0]         o_sat_count,
`endif
  round_sat_arbiter_if.slave  bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int T_W  = IN_W - FRAC_W + 1;
  localparam logic signed [31:0] SAT_P = 32'(SAT_MAX);
  localparam logic signed [31:0] SAT_N = -32'(SAT_MAX);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic                 r_out_valid;
  logic [OUT_W-1:0]     r_out_data;
  logic [ID_W-1:0]      r_out_id;
  logic                 r_sat_flag;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [15:0]          r_lfsr;

  logic                 w_can_acc;
  logic                 w_gnt_vld;
  logic [ID_W-1:0]      w_gnt;
  logic [ID_W-1:0]      w_idx;
  logic                 w_xfer;
  logic [IN_W-1:0]      w_words [NREQ];
  logic [IN_W-1:0]      w_word;
  logic signed [IN_W-1:0] w_sh;
  logic [T_W-1:0]       w_t;
  logic                 w_inc;
  logic [T_W-1:0]       w_r;
  logic signed [31:0]   w_r32;
  logic [OUT_W-1:0]     w_res;
  logic                 w_sat;
  logic [15:0]          w_lfsr_nxt;
  logic [ID_W-1:0]      w_rr_nxt;

  assign w_can_acc = !r_out_valid || bus.out_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_gnt_vld && bus.req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  assign w_xfer = w_gnt_vld && w_can_acc && !i_rst;

  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) bus.req_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < NREQ; k++) w_words[k] = bus.req_data[k*IN_W +: IN_W];
  end

  assign w_word = w_words[w_gnt];
  assign w_sh   = $signed(w_word) >>> FRAC_W;
  assign w_t    = {w_sh[IN_W-FRAC_W-1], w_sh[IN_W-FRAC_W-1:0]};
  // Stochastic rounds up with probability f / 2^FRAC_W using the low LFSR bits.
  assign w_inc  = bus.mode ? (r_lfsr[FRAC_W-1:0] < w_word[FRAC_W-1:0]) : w_word[FRAC_W-1];
  assign w_r    = w_t + T_W'(w_inc);
  assign w_r32  = {{(32-T_W){w_r[T_W-1]}}, w_r};

  always_comb begin
    w_sat = 1'b0;
    w_res = w_r32[OUT_W-1:0];
    if (w_r32 > SAT_P) begin
      w_sat = 1'b1;
      w_res = SAT_P[OUT_W-1:0];
    end else if (w_r32 < SAT_N) begin
      w_sat = 1'b1;
      w_res = SAT_N[OUT_W-1:0];
    end
  end

  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_rr_nxt   = ID_W'((int'(w_gnt) + 1) % NREQ);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_sat_flag  <= 1'b0;
      r_rr_ptr    <= '0;
      r_lfsr      <= SEED;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_id    <= w_gnt;
      r_sat_flag  <= w_sat;
      r_rr_ptr    <= w_rr_nxt;
      if (bus.mode) r_lfsr <= w_lfsr_nxt;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.sat_flag  = r_sat_flag;

`ifdef SAT_STATS_EN
  logic [15:0] r_sat_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sat_count <= '0;
    end else if (i_stats_clr) begin
      r_sat_count <= '0;
    end else if (w_xfer && w_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign o_sat_count = r_sat_count;
`endif
endmodule
